// File: rtl/mem_arbiter.sv
// Arbiter that shares one word-addressed memory between the fetch port and the data port.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT denials.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RESP_IDLE | no response this cycle
// RESP_IF   | fetch response presented (if_resp_valid pulse)
// RESP_D    | data response presented (d_resp_valid pulse)
module mem_arbiter #(
    parameter int MEM_DEPTH    = 8192,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        fetch_starved
);

    localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);
    localparam logic [3:0]  LIMIT_W = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_state_t;

    resp_state_t resp_state;
    resp_state_t resp_state_nxt;
    logic [31:0] resp_data_q;
    logic [31:0] resp_data_nxt;
    logic        resp_err_q;
    logic        resp_err_nxt;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_nxt;

    logic        grant_if;
    logic        grant_d;
    logic        if_legal;
    logic        d_legal;

    always_comb begin
        if_legal = (if_req_addr[1:0] == 2'b00) && (if_req_addr[31:2] < DEPTH_W);
        d_legal  = (d_req_addr[1:0] == 2'b00) && (d_req_addr[31:2] < DEPTH_W);
    end

    // Data yields only when the fetch side has hit the limit and is actually waiting.
    always_comb begin
        grant_d  = !reset && d_req_valid && ((starve_cnt < LIMIT_W) || !if_req_valid);
        grant_if = !reset && if_req_valid && !grant_d;
    end

    always_comb begin
        if_req_ready  = grant_if;
        d_req_ready   = grant_d;
        fetch_starved = (starve_cnt == LIMIT_W);
        mem_we        = grant_d && d_req_we && d_legal;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        if (grant_d) begin
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
        end else if (grant_if) begin
            mem_addr  = if_req_addr;
        end
    end

    always_comb begin
        resp_state_nxt = RESP_IDLE;
        resp_data_nxt  = 32'h0;
        resp_err_nxt   = 1'b0;
        if (grant_if) begin
            resp_state_nxt = RESP_IF;
            resp_err_nxt   = !if_legal;
            if (if_legal) begin
                resp_data_nxt = mem_rdata;
            end
        end else if (grant_d) begin
            resp_state_nxt = RESP_D;
            resp_err_nxt   = !d_legal;
            if (d_legal && !d_req_we) begin
                resp_data_nxt = mem_rdata;
            end
        end
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!if_req_valid || grant_if) begin
            starve_cnt_nxt = 4'd0;
        end else if (starve_cnt < LIMIT_W) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_state  <= RESP_IDLE;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
            starve_cnt  <= 4'd0;
        end else begin
            resp_state  <= resp_state_nxt;
            resp_data_q <= resp_data_nxt;
            resp_err_q  <= resp_err_nxt;
            starve_cnt  <= starve_cnt_nxt;
        end
    end

    // One shared response register; the state steers it to exactly one port.
    always_comb begin
        if_resp_valid = (resp_state == RESP_IF);
        d_resp_valid  = (resp_state == RESP_D);
        if_resp_data  = if_resp_valid ? resp_data_q : 32'h0;
        if_resp_err   = if_resp_valid && resp_err_q;
        d_resp_data   = d_resp_valid ? resp_data_q : 32'h0;
        d_resp_err    = d_resp_valid && resp_err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against a
// cycle-level reference model of the arbitration rules and an independent memory image.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 8192;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        if_resp_err;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        fetch_starved;

    mem_arbiter #(.MEM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fetch_starved(fetch_starved)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'h0050_0093;
        return 32'(i) * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    // Attached memory: combinational read, write committed on the clock edge.
    logic [31:0] tb_mem [DEPTH];
    assign mem_rdata = (mem_addr[31:15] == 17'h0) ? tb_mem[mem_addr[14:2]] : 32'h0;

    initial begin
        logic        w_en;
        logic [12:0] w_idx;
        logic [31:0] w_dat;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = init_word(i);
        forever begin
            @(negedge clock);
            w_en  = mem_we && (mem_addr[31:15] == 17'h0);
            w_idx = mem_addr[14:2];
            w_dat = mem_wdata;
            @(posedge clock);
            if (w_en) tb_mem[w_idx] = w_dat;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          starve;
    logic        e_if_v, e_if_e, e_d_v, e_d_e;
    logic [31:0] e_if_d, e_d_d;
    logic        last_gf, last_gd;
    logic        obs_if_rdy, obs_d_rdy, obs_starved, obs_we;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
    endfunction

    task automatic cycle();
        logic        gd, gf, if_ok, d_ok;
        logic [31:0] exp_addr, exp_wdata;
        @(negedge clock);
        gd = !reset && d_req_valid && ((starve < LIMIT) || !if_req_valid);
        gf = !reset && if_req_valid && !gd;
        if_ok = legal(if_req_addr);
        d_ok  = legal(d_req_addr);
        exp_addr  = gd ? d_req_addr : (gf ? if_req_addr : 32'h0);
        exp_wdata = gd ? d_req_wdata : 32'h0;
        chk("if_req_ready", 32'(if_req_ready), 32'(gf));
        chk("d_req_ready", 32'(d_req_ready), 32'(gd));
        chk("mem_we", 32'(mem_we), 32'(gd && d_req_we && d_ok));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("fetch_starved", 32'(fetch_starved), 32'(starve == LIMIT));
        obs_if_rdy  = if_req_ready;
        obs_d_rdy   = d_req_ready;
        obs_starved = fetch_starved;
        obs_we      = mem_we;
        last_gf = gf;
        last_gd = gd;
        @(posedge clock);
        e_if_v = 1'b0; e_if_e = 1'b0; e_if_d = 32'h0;
        e_d_v  = 1'b0; e_d_e  = 1'b0; e_d_d  = 32'h0;
        if (!reset) begin
            if (gf) begin
                e_if_v = 1'b1;
                e_if_e = !if_ok;
                if (if_ok) e_if_d = ref_mem[if_req_addr[14:2]];
            end
            if (gd) begin
                e_d_v = 1'b1;
                e_d_e = !d_ok;
                if (d_ok && !d_req_we) e_d_d = ref_mem[d_req_addr[14:2]];
                if (d_ok && d_req_we) ref_mem[d_req_addr[14:2]] = d_req_wdata;
            end
        end
        if (reset || !if_req_valid || gf) starve = 0;
        else if (starve < LIMIT) starve = starve + 1;
        #1;
        chk("if_resp_valid", 32'(if_resp_valid), 32'(e_if_v));
        chk("if_resp_data", if_resp_data, e_if_d);
        chk("if_resp_err", 32'(if_resp_err), 32'(e_if_e));
        chk("d_resp_valid", 32'(d_resp_valid), 32'(e_d_v));
        chk("d_resp_data", d_resp_data, e_d_d);
        chk("d_resp_err", 32'(d_resp_err), 32'(e_d_e));
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return {24'h0, 2'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        if (r == 1) return 32'h0000_8000 + 32'($urandom_range(0, 63)) * 4;
        if (r == 2) return $urandom | 32'h8000_0000;
        return 32'($urandom_range(0, 63)) * 4;
    endfunction

    initial begin
        logic [9:0] cont_f;
        cont_f = 10'b10_0001_0000;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        starve = 0;

        // Reset with both requesters asserting: no grants, no write
        reset = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'h1111_2222;
        @(posedge clock); #1;
        cycle();
        chk("rst_if_ready", 32'(obs_if_rdy), 32'h0);
        chk("rst_d_ready", 32'(obs_d_rdy), 32'h0);
        chk("rst_mem_we", 32'(obs_we), 32'h0);
        cycle();
        reset = 1'b0;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        cycle();

        // Basic fetch
        if_req_valid = 1'b1; if_req_addr = 32'h0000_000C;
        cycle();
        chk("fetch_ready", 32'(obs_if_rdy), 32'h1);
        chk("fetch_data", if_resp_data, 32'h0050_0093);
        chk("fetch_err", 32'(if_resp_err), 32'h0);
        if_req_valid = 1'b0;

        // Store then load to the same word
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h100; d_req_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("store_we", 32'(obs_we), 32'h1);
        chk("store_resp_valid", 32'(d_resp_valid), 32'h1);
        d_req_we = 1'b0; d_req_wdata = 32'h0;
        cycle();
        chk("load_we", 32'(obs_we), 32'h0);
        chk("load_data", d_resp_data, 32'hDEAD_BEEF);
        d_req_valid = 1'b0;
        cycle();

        // Contention: fetch must win every fifth cycle
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("cont_if_grant", 32'(obs_if_rdy), 32'(cont_f[i]));
            chk("cont_d_grant", 32'(obs_d_rdy), 32'(!cont_f[i]));
            chk("cont_starved", 32'(obs_starved), 32'(cont_f[i]));
            if (last_gd) d_req_addr = d_req_addr + 32'h4;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        cycle();

        // Illegal store (out of range) and illegal load (misaligned)
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h0000_8000; d_req_wdata = 32'hCAFE_F00D;
        cycle();
        chk("ill_store_we", 32'(obs_we), 32'h0);
        chk("ill_store_err", 32'(d_resp_err), 32'h1);
        chk("ill_store_data", d_resp_data, 32'h0);
        d_req_we = 1'b0; d_req_addr = 32'h0000_0102; d_req_wdata = 32'h0;
        cycle();
        chk("ill_load_we", 32'(obs_we), 32'h0);
        chk("ill_load_err", 32'(d_resp_err), 32'h1);
        chk("ill_load_data", d_resp_data, 32'h0);
        d_req_valid = 1'b0;

        // Priority without starvation; counter clears when fetch goes idle
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        cycle();
        if_req_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = 32'h24;
        cycle();
        chk("prio_d_now", 32'(obs_d_rdy), 32'h1);
        if_req_valid = 1'b1;
        cycle();
        cycle();
        if_req_valid = 1'b0;
        cycle();
        chk("prio_cnt_clear", 32'(obs_starved), 32'h0);
        if_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("prio_if_grant", 32'(obs_if_rdy), 32'(i == 4));
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        cycle();

        // Reset while a load response is being presented
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h100;
        cycle();
        reset = 1'b1;
        cycle();
        chk("rstmid_d_ready", 32'(obs_d_rdy), 32'h0);
        chk("rstmid_no_pulse", 32'(d_resp_valid), 32'h0);
        reset = 1'b0; d_req_valid = 1'b0;
        cycle();
        chk("rstmid_after", 32'(d_resp_valid), 32'h0);

        // Random traffic obeying the hold-until-ready protocol
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            if (if_req_valid && last_gf) if_req_valid = 1'b0;
            if (d_req_valid && last_gd) d_req_valid = 1'b0;
            if (!if_req_valid && $urandom_range(0, 2) != 0) begin
                if_req_valid = 1'b1;
                if_req_addr  = rand_addr();
            end
            if (!d_req_valid && $urandom_range(0, 2) != 0) begin
                d_req_valid = 1'b1;
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_addr  = rand_addr();
                d_req_wdata = $urandom;
            end
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
